// File: rtl/hdmi_fb_pkg.sv
// Shared types and helpers for the framebuffer write arbiter.
// Holds the pixel type, the clear-engine state enum and the address-width helper.
package hdmi_fb_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int fb_addr_bits(input int fb_x, input int fb_y);
    return $clog2(fb_x * fb_y);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
// The grant is combinational; the search starts at the pointer and wraps modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  i_req,
  input  logic          i_advance,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_grant_idx,
  output logic          o_grant_any,
  output logic [IW-1:0] o_ptr
);

  logic [IW-1:0] r_ptr;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_found;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % N;
    return IW'(s);
  endfunction

  // First requester at or after the pointer wins.
  always_comb begin
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[rr_idx(r_ptr, k)]) begin
        w_found                    = 1'b1;
        w_idx                      = rr_idx(r_ptr, k);
        w_grant[rr_idx(r_ptr, k)]  = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (i_advance && w_found) begin
      r_ptr <= (w_idx == IW'(N - 1)) ? '0 : w_idx + 1'b1;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_grant     = w_grant;
  assign o_grant_idx = w_idx;
  assign o_grant_any = w_found;
  assign o_ptr       = r_ptr;

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between NREQ pixel producers and a
// full-frame clear engine; all pxl_* and status outputs are registered.
module fb_write_arbiter
  import hdmi_fb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int FB_X = 1280,
  parameter int FB_Y = 720,
  localparam int FB_ADDR_BITS = fb_addr_bits(FB_X, FB_Y),
  localparam int PIXELS = FB_X * FB_Y,
  localparam int ID_BITS = $clog2(NREQ)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NREQ-1:0]              req_valid_i,
  input  logic [NREQ*FB_ADDR_BITS-1:0] req_addr_i,
  input  logic [NREQ*24-1:0]           req_data_i,
  output logic [NREQ-1:0]              req_ready_o,
  input  logic                         clear_start_i,
  input  rgb_t                         clear_color_i,
  output logic                         clear_busy_o,
  output logic                         clear_done_o,
  output logic                         drop_o,
  output logic [ID_BITS-1:0]           grant_id_o,
  output logic [FB_ADDR_BITS-1:0]      pxl_addr_o,
  output rgb_t                         pxl_data_o,
  output logic                         pxl_en_o
);

  localparam int AW1 = FB_ADDR_BITS + 1;
  localparam logic [FB_ADDR_BITS:0]   PIX_LIMIT = AW1'(PIXELS);
  localparam logic [FB_ADDR_BITS-1:0] LAST_ADDR = FB_ADDR_BITS'(PIXELS - 1);

  clr_state_e              r_state, w_state_nxt;
  logic [FB_ADDR_BITS-1:0] r_cnt, w_cnt_nxt;
  rgb_t                    r_color, w_color_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_drop, w_drop_nxt;
  logic                    r_pxl_en, w_en_nxt;
  logic [FB_ADDR_BITS-1:0] r_pxl_addr, w_addr_nxt;
  rgb_t                    r_pxl_data, w_data_nxt;
  logic [ID_BITS-1:0]      r_grant_id, w_id_nxt;

  logic [NREQ-1:0]         w_req;
  logic [NREQ-1:0]         w_grant;
  logic [ID_BITS-1:0]      w_idx;
  logic [ID_BITS-1:0]      w_ptr;
  logic                    w_any;
  logic                    w_idle;
  logic [FB_ADDR_BITS-1:0] w_sel_addr;
  rgb_t                    w_sel_data;
  logic                    w_in_range;

  assign w_idle = (r_state == IDLE);
  assign w_req  = w_idle ? req_valid_i : '0;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .i_req       (w_req),
    .i_advance   (w_idle),
    .o_grant     (w_grant),
    .o_grant_idx (w_idx),
    .o_grant_any (w_any),
    .o_ptr       (w_ptr)
  );

  // Grant is one-hot, so OR-ing the masked lanes selects the winner.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_addr = w_sel_addr | req_addr_i[i*FB_ADDR_BITS +: FB_ADDR_BITS];
        w_sel_data = w_sel_data | req_data_i[i*24 +: 24];
      end else begin
        w_sel_addr = w_sel_addr;
      end
    end
  end

  assign w_in_range = ({1'b0, w_sel_addr} < PIX_LIMIT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_color_nxt = r_color;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_drop_nxt  = 1'b0;
    w_en_nxt    = 1'b0;
    w_addr_nxt  = '0;
    w_data_nxt  = '0;
    w_id_nxt    = '0;
    case (r_state)
      IDLE: begin
        if (w_any && w_in_range) begin
          w_en_nxt   = 1'b1;
          w_addr_nxt = w_sel_addr;
          w_data_nxt = w_sel_data;
          w_id_nxt   = w_idx;
        end else if (w_any) begin
          w_drop_nxt = 1'b1;
        end else begin
          w_en_nxt = 1'b0;
        end
        if (clear_start_i) begin
          w_color_nxt = clear_color_i;
          w_cnt_nxt   = '0;
          w_state_nxt = CLEAR;
          w_busy_nxt  = 1'b1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CLEAR: begin
        w_busy_nxt = 1'b1;
        w_en_nxt   = 1'b1;
        w_addr_nxt = r_cnt;
        w_data_nxt = r_color;
        // Counter parks at the last address instead of wrapping.
        if (r_cnt == LAST_ADDR) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_color    <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_drop     <= 1'b0;
      r_pxl_en   <= 1'b0;
      r_pxl_addr <= '0;
      r_pxl_data <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_color    <= w_color_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_drop     <= w_drop_nxt;
      r_pxl_en   <= w_en_nxt;
      r_pxl_addr <= w_addr_nxt;
      r_pxl_data <= w_data_nxt;
      r_grant_id <= w_id_nxt;
    end
  end

  assign req_ready_o  = w_grant;
  assign clear_busy_o = r_busy;
  assign clear_done_o = r_done;
  assign drop_o       = r_drop;
  assign grant_id_o   = r_grant_id;
  assign pxl_addr_o   = r_pxl_addr;
  assign pxl_data_o   = r_pxl_data;
  assign pxl_en_o     = r_pxl_en;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on an 8x4 frame, plus an 8x3 instance
// whose unused top addresses exercise the out-of-range drop path.
module tb_fb_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  valid;
  logic [19:0] addr;
  logic [95:0] data;
  logic [3:0]  ready;
  logic        cstart;
  logic [23:0] ccolor;
  logic        busy, done, drop, pen;
  logic [1:0]  gid;
  logic [4:0]  paddr;
  logic [23:0] pdata;

  logic [3:0]  valid2;
  logic [19:0] addr2;
  logic [95:0] data2;
  logic [3:0]  ready2;
  logic        cstart2;
  logic [23:0] ccolor2;
  logic        busy2, done2, drop2, pen2;
  logic [1:0]  gid2;
  logic [4:0]  paddr2;
  logic [23:0] pdata2;

  fb_write_arbiter #(.NREQ(4), .FB_X(8), .FB_Y(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid), .req_addr_i(addr), .req_data_i(data),
    .req_ready_o(ready), .clear_start_i(cstart), .clear_color_i(ccolor),
    .clear_busy_o(busy), .clear_done_o(done), .drop_o(drop), .grant_id_o(gid),
    .pxl_addr_o(paddr), .pxl_data_o(pdata), .pxl_en_o(pen)
  );

  fb_write_arbiter #(.NREQ(4), .FB_X(8), .FB_Y(3)) dut_small (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid2), .req_addr_i(addr2), .req_data_i(data2),
    .req_ready_o(ready2), .clear_start_i(cstart2), .clear_color_i(ccolor2),
    .clear_busy_o(busy2), .clear_done_o(done2), .drop_o(drop2), .grant_id_o(gid2),
    .pxl_addr_o(paddr2), .pxl_data_o(pdata2), .pxl_en_o(pen2)
  );

  typedef struct {
    logic [3:0]        valid;
    logic [3:0][4:0]   addr;
    logic [3:0][23:0]  data;
    logic [3:0]        exp_ready;
    logic              exp_en;
    logic [4:0]        exp_addr;
    logic [23:0]       exp_data;
    logic [1:0]        exp_id;
  } vec_t;

  localparam logic [3:0][4:0]  A = {5'd20, 5'd5, 5'd9, 5'd7};
  localparam logic [3:0][23:0] D = {24'h00BB00, 24'hFF0000, 24'h123456, 24'h0000AA};

  vec_t tbl [12];
  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [3:0] r, input logic en,
                              input logic [4:0] a, input logic [23:0] d, input logic [1:0] id);
    vec_t t;
    t.valid = v; t.addr = A; t.data = D;
    t.exp_ready = r; t.exp_en = en; t.exp_addr = a; t.exp_data = d; t.exp_id = id;
    return t;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int  done_seen;
    bit  found;

    tbl[0]  = mk(4'b0100, 4'b0100, 1'b1, 5'd5,  24'hFF0000, 2'd2);
    tbl[1]  = mk(4'b0000, 4'b0000, 1'b0, 5'd0,  24'h000000, 2'd0);
    tbl[2]  = mk(4'b0010, 4'b0010, 1'b1, 5'd9,  24'h123456, 2'd1);
    tbl[3]  = mk(4'b1010, 4'b1000, 1'b1, 5'd20, 24'h00BB00, 2'd3);
    tbl[4]  = mk(4'b1010, 4'b0010, 1'b1, 5'd9,  24'h123456, 2'd1);
    tbl[5]  = mk(4'b0010, 4'b0010, 1'b1, 5'd31, 24'hABCDEF, 2'd1);
    tbl[5].addr[1] = 5'd31;
    tbl[5].data[1] = 24'hABCDEF;
    tbl[6]  = mk(4'b1111, 4'b0100, 1'b1, 5'd5,  24'hFF0000, 2'd2);
    tbl[7]  = mk(4'b1111, 4'b1000, 1'b1, 5'd20, 24'h00BB00, 2'd3);
    tbl[8]  = mk(4'b0001, 4'b0001, 1'b1, 5'd7,  24'h0000AA, 2'd0);
    tbl[9]  = mk(4'b1001, 4'b1000, 1'b1, 5'd20, 24'h00BB00, 2'd3);
    tbl[10] = mk(4'b1001, 4'b0001, 1'b1, 5'd7,  24'h0000AA, 2'd0);
    tbl[11] = mk(4'b0000, 4'b0000, 1'b0, 5'd0,  24'h000000, 2'd0);

    rst = 1'b1; valid = 4'd0; addr = '0; data = '0; cstart = 1'b0; ccolor = 24'd0;
    valid2 = 4'd0; addr2 = '0; data2 = '0; cstart2 = 1'b0; ccolor2 = 24'd0;
    @(posedge clk); #1;
    chk("rst_en", {31'd0, pen}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outs", {done, drop, gid, paddr, pdata}, 32'd0);
    chk("rst_ready", {28'd0, ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_en", {31'd0, pen}, 32'd0);

    // Single-cycle vectors: scenario 1, pointer wrap/skip, top address, mixed.
    for (int i = 0; i < 12; i++) begin
      valid = tbl[i].valid; addr = tbl[i].addr; data = tbl[i].data;
      #1;
      chk($sformatf("v%0d_ready", i), {28'd0, ready}, {28'd0, tbl[i].exp_ready});
      @(posedge clk); #1;
      chk($sformatf("v%0d_en", i), {31'd0, pen}, {31'd0, tbl[i].exp_en});
      chk($sformatf("v%0d_drop", i), {31'd0, drop}, 32'd0);
      if (tbl[i].exp_en) begin
        chk($sformatf("v%0d_addr", i), {27'd0, paddr}, {27'd0, tbl[i].exp_addr});
        chk($sformatf("v%0d_data", i), {8'd0, pdata}, {8'd0, tbl[i].exp_data});
        chk($sformatf("v%0d_id", i), {30'd0, gid}, {30'd0, tbl[i].exp_id});
      end
    end

    // Full clear with requesters hammering and a second start ignored.
    valid = 4'd0; cstart = 1'b1; ccolor = 24'h00FF00;
    #1;
    chk("clr_t_ready", {28'd0, ready}, 32'd0);
    @(posedge clk); #1;
    for (int k = 1; k <= 34; k++) begin
      chk($sformatf("clr%0d_busy", k), {31'd0, busy}, {31'd0, (k <= 33)});
      chk($sformatf("clr%0d_en", k), {31'd0, pen}, {31'd0, (k >= 2 && k <= 33)});
      chk($sformatf("clr%0d_done", k), {31'd0, done}, {31'd0, (k == 33)});
      if (k >= 2 && k <= 33) begin
        chk($sformatf("clr%0d_addr", k), {27'd0, paddr}, 32'(k - 2));
        chk($sformatf("clr%0d_data", k), {8'd0, pdata}, 32'h00FF00);
        chk($sformatf("clr%0d_id", k), {30'd0, gid}, 32'd0);
      end
      cstart = (k == 10);
      ccolor = (k == 10) ? 24'h0000FF : 24'h00FF00;
      valid  = (k <= 32) ? 4'hF : 4'h0;
      #1;
      if (k <= 32) chk($sformatf("clr%0d_ready", k), {28'd0, ready}, 32'd0);
      @(posedge clk); #1;
    end
    cstart = 1'b0; valid = 4'd0;

    // Start and request together, then reset mid-fill.
    cstart = 1'b1; ccolor = 24'h112233; valid = 4'b0001;
    #1;
    chk("sim_ready", {28'd0, ready}, 32'h1);
    @(posedge clk); #1;
    cstart = 1'b0; valid = 4'd0;
    chk("sim_req_en", {31'd0, pen}, 32'd1);
    chk("sim_req_addr", {27'd0, paddr}, 32'd7);
    chk("sim_req_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("sim_fill0_en", {31'd0, pen}, 32'd1);
    chk("sim_fill0_addr", {27'd0, paddr}, 32'd0);
    chk("sim_fill0_data", {8'd0, pdata}, 32'h112233);
    found = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(posedge clk); #1;
      if (pen && paddr == 5'd12) found = 1'b1;
    end
    chk("abort_reach12", {31'd0, found}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_en", {31'd0, pen}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_outs", {done, drop, gid, paddr, pdata}, 32'd0);
    chk("abort_ready", {28'd0, ready}, 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done || busy || pen) done_seen++;
    end
    chk("abort_quiet", done_seen, 32'd0);

    // Fairness from reset: all four valid for eight cycles.
    for (int k = 0; k < 8; k++) begin
      valid = 4'hF;
      #1;
      chk($sformatf("fair%0d_ready", k), {28'd0, ready}, 32'(1 << (k % 4)));
      @(posedge clk); #1;
      chk($sformatf("fair%0d_en", k), {31'd0, pen}, 32'd1);
      chk($sformatf("fair%0d_id", k), {30'd0, gid}, 32'(k % 4));
    end
    valid = 4'd0;

    // Out-of-range on the 8x3 frame (24 pixels): 24 and 31 drop, 23 writes.
    data2[1*24 +: 24] = 24'h445566;
    valid2 = 4'b0010;
    addr2[1*5 +: 5] = 5'd24;
    #1;
    chk("oor24_ready", {28'd0, ready2}, 32'h2);
    @(posedge clk); #1;
    chk("oor24_en", {31'd0, pen2}, 32'd0);
    chk("oor24_drop", {31'd0, drop2}, 32'd1);
    addr2[1*5 +: 5] = 5'd31;
    #1;
    chk("oor31_ready", {28'd0, ready2}, 32'h2);
    @(posedge clk); #1;
    chk("oor31_en", {31'd0, pen2}, 32'd0);
    chk("oor31_drop", {31'd0, drop2}, 32'd1);
    addr2[1*5 +: 5] = 5'd23;
    #1;
    chk("in23_ready", {28'd0, ready2}, 32'h2);
    @(posedge clk); #1;
    chk("in23_en", {31'd0, pen2}, 32'd1);
    chk("in23_drop", {31'd0, drop2}, 32'd0);
    chk("in23_addr", {27'd0, paddr2}, 32'd23);
    chk("in23_data", {8'd0, pdata2}, 32'h445566);
    chk("in23_id", {30'd0, gid2}, 32'd1);
    valid2 = 4'd0;
    @(posedge clk); #1;
    chk("oor_idle_drop", {31'd0, drop2}, 32'd0);
    chk("oor_idle_en", {31'd0, pen2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
